// File: rtl/mux_tree_pkg.sv
// -----------------------------------------------------------------------------
// mux_tree_pkg
// Shared elaboration-time helpers for the pipelined mux tree:
//   clog2_int(n)              : ceil(log2(n)), 0 for n <= 1
//   sel_width(n)              : selector width, never below 1
//   level_width(n, i)         : number of words entering tree level i
//   stage_count(n, every)     : number of register stages in the pipeline
//   is_reg_level(j, l, every) : 1 when a register follows tree level j
// -----------------------------------------------------------------------------
package mux_tree_pkg;

    function automatic int clog2_int(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? clog2_int(n) : 1;
    endfunction

    // Each level halves the word count, rounding up so an odd leftover survives.
    function automatic int level_width(input int n, input int i);
        int w;
        w = n;
        for (int k = 0; k < i; k++) begin
            w = (w + 1) / 2;
        end
        return w;
    endfunction

    // A single-input mux still gets one register stage.
    function automatic int stage_count(input int n, input int every);
        int s;
        s = (clog2_int(n) + every - 1) / every;
        return (s < 1) ? 1 : s;
    endfunction

    // The final level is always registered so the outputs come from flops.
    function automatic bit is_reg_level(input int j, input int l, input int every);
        return (((j + 1) % every) == 0) || (j == l - 1);
    endfunction

endpackage

// File: rtl/mux_tree_level.sv
// -----------------------------------------------------------------------------
// mux_tree_level
// One combinational level of the mux tree. Word pairs (2j, 2j+1) are reduced
// to word j by one selector bit; an odd last word is forwarded untouched.
// Ports:
//   sel       : selector bit for this level (1 picks the odd word of a pair)
//   in_words  : N_IN packed words, word k at [k*DATA_W +: DATA_W]
//   out_words : ceil(N_IN/2) packed words for the next level
// -----------------------------------------------------------------------------
module mux_tree_level #(
    parameter int N_IN   = 2,
    parameter int DATA_W = 8
) (
    input  logic                               sel,
    input  logic [N_IN*DATA_W-1:0]             in_words,
    output logic [((N_IN+1)/2)*DATA_W-1:0]     out_words
);

    localparam int N_PAIRS = N_IN / 2;

    for (genvar gi = 0; gi < N_PAIRS; gi++) begin : g_pair
        assign out_words[gi*DATA_W +: DATA_W] = sel ? in_words[(2*gi+1)*DATA_W +: DATA_W]
                                                    : in_words[(2*gi)*DATA_W +: DATA_W];
    end

    // The leftover word ignores sel, which is why out-of-range selectors
    // alias onto the last input and must be caught at the tree entrance.
    if ((N_IN % 2) == 1) begin : g_odd
        assign out_words[N_PAIRS*DATA_W +: DATA_W] = in_words[(N_IN-1)*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
// Pipelined N:1 word multiplexer built from 2:1 tree levels with a register
// after every STAGE_EVERY levels (and always after the last one). Each word
// travels with its remaining selector bits and a range-error flag.
// Flow control is a global stall: every stage moves when the output is empty
// or being consumed.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake
//   in_sel               : index of the word to select
//   in_data              : MUX_SIZE packed words
//   out_valid / out_ready: output handshake
//   out_data             : selected word (0 when out of range)
//   out_err              : in_sel was >= MUX_SIZE for this word
// -----------------------------------------------------------------------------
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int  MUX_SIZE    = 8,
    parameter int  DATA_W      = 8,
    parameter int  STAGE_EVERY = 1,
    localparam int SEL_W       = sel_width(MUX_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [MUX_SIZE*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_err
);

    localparam int              LEVELS    = clog2_int(MUX_SIZE);
    localparam logic [SEL_W:0]  SEL_LIMIT = (SEL_W+1)'(MUX_SIZE);

    logic advance;
    logic accept;
    logic in_err;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;
    assign in_err   = ({1'b0, in_sel} >= SEL_LIMIT);

    if (LEVELS == 0) begin : g_single
        // One input: no tree, just the output register.
        logic              valid_reg;
        logic              err_reg;
        logic [DATA_W-1:0] data_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                err_reg   <= 1'b0;
                data_reg  <= '0;
            end else if (advance) begin
                valid_reg <= accept;
                if (accept) begin
                    err_reg  <= in_err;
                    data_reg <= in_err ? '0 : in_data;
                end
            end
        end

        assign out_valid = valid_reg;
        assign out_err   = err_reg;
        assign out_data  = data_reg;
    end else begin : g_tree
        for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
            localparam int N_I  = level_width(MUX_SIZE, gi);
            localparam int N_O  = level_width(MUX_SIZE, gi + 1);
            localparam int SW   = SEL_W - gi;          // selector bits still unused
            localparam bit LAST = (gi == LEVELS - 1);
            localparam bit REG  = is_reg_level(gi, LEVELS, STAGE_EVERY);

            logic                  v_in;
            logic                  err_in;
            logic [SW-1:0]         sel_in;
            logic [N_I*DATA_W-1:0] words_in;
            logic [N_O*DATA_W-1:0] words_comb;
            logic [N_O*DATA_W-1:0] words_next;
            logic                  v_out;
            logic                  err_out;
            logic [N_O*DATA_W-1:0] words_out;

            if (gi == 0) begin : g_src
                assign v_in     = accept;
                assign err_in   = in_err;
                assign sel_in   = in_sel;
                assign words_in = in_data;
            end else begin : g_src
                assign v_in     = g_level[gi-1].v_out;
                assign err_in   = g_level[gi-1].err_out;
                assign sel_in   = g_level[gi-1].g_sel.sel_out;
                assign words_in = g_level[gi-1].words_out;
            end

            mux_tree_level #(
                .N_IN   (N_I),
                .DATA_W (DATA_W)
            ) u_level (
                .sel       (sel_in[0]),
                .in_words  (words_in),
                .out_words (words_comb)
            );

            // The tree result of an out-of-range word is replaced by zero as
            // it enters the output register.
            assign words_next = (LAST && err_in) ? '0 : words_comb;

            if (REG) begin : g_reg
                logic                  valid_reg;
                logic                  err_reg;
                logic [N_O*DATA_W-1:0] words_reg;

                // Payload loads only with a valid word, so bubbles leave the
                // previous contents (and the output) untouched.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        valid_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        words_reg <= '0;
                    end else if (advance) begin
                        valid_reg <= v_in;
                        if (v_in) begin
                            err_reg   <= err_in;
                            words_reg <= words_next;
                        end
                    end
                end

                assign v_out     = valid_reg;
                assign err_out   = err_reg;
                assign words_out = words_reg;
            end else begin : g_comb
                assign v_out     = v_in;
                assign err_out   = err_in;
                assign words_out = words_next;
            end

            // Only levels that feed another level carry selector bits onward.
            if (!LAST) begin : g_sel
                logic [SW-2:0] sel_out;

                if (REG) begin : g_r
                    logic [SW-2:0] sel_reg;

                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            sel_reg <= '0;
                        end else if (advance && v_in) begin
                            sel_reg <= sel_in[SW-1:1];
                        end
                    end

                    assign sel_out = sel_reg;
                end else begin : g_c
                    assign sel_out = sel_in[SW-1:1];
                end
            end
        end

        assign out_valid = g_level[LEVELS-1].v_out;
        assign out_err   = g_level[LEVELS-1].err_out;
        assign out_data  = g_level[LEVELS-1].words_out;
    end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_tree_pipe
// Self-checking bench for mux_tree_pipe. Four instances cover N=8 and N=5
// (one level per stage) and N=1, N=2 (single stage). A reference model keeps
// a queue of expected {word, err} per streaming instance: the expected word
// is simply input word[sel] when sel < N, else 0 with err set.
// -----------------------------------------------------------------------------
module tb_mux_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // N=8, STAGE_EVERY=1 (3 stages)
    logic       v8, r8, ov8, or8, oe8;
    logic [2:0] s8;
    logic [63:0] d8;
    logic [7:0] od8;
    logic [7:0] w8 [8];

    // N=5, STAGE_EVERY=1 (3 stages)
    logic       v5, r5, ov5, or5, oe5;
    logic [2:0] s5;
    logic [39:0] d5;
    logic [7:0] od5;
    logic [7:0] w5 [5];

    // N=1, STAGE_EVERY=4 (1 stage)
    logic       v1, r1, ov1, or1, oe1;
    logic [0:0] s1;
    logic [7:0] d1, od1;

    // N=2, STAGE_EVERY=4 (1 stage)
    logic       v2, r2, ov2, or2, oe2;
    logic [0:0] s2;
    logic [15:0] d2;
    logic [7:0] od2;
    logic [7:0] w2 [2];

    for (genvar gi = 0; gi < 8; gi++) begin : g_p8
        assign d8[gi*8 +: 8] = w8[gi];
    end
    for (genvar gi = 0; gi < 5; gi++) begin : g_p5
        assign d5[gi*8 +: 8] = w5[gi];
    end
    assign d2 = {w2[1], w2[0]};

    mux_tree_pipe #(.MUX_SIZE(8), .DATA_W(8), .STAGE_EVERY(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_sel(s8), .in_data(d8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_err(oe8));

    mux_tree_pipe #(.MUX_SIZE(5), .DATA_W(8), .STAGE_EVERY(1)) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5), .in_sel(s5), .in_data(d5),
        .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_err(oe5));

    mux_tree_pipe #(.MUX_SIZE(1), .DATA_W(8), .STAGE_EVERY(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_sel(s1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_err(oe1));

    mux_tree_pipe #(.MUX_SIZE(2), .DATA_W(8), .STAGE_EVERY(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_sel(s2), .in_data(d2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_err(oe2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model / scoreboards ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];

    // Sampled on the falling edge: handshakes seen here complete on the
    // next rising edge. Outputs are retired before new inputs are queued.
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            q8.delete();
            q5.delete();
        end else begin
            if (ov8 && or8) begin
                chk("u8_pending", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    x = q8.pop_front();
                    chk("u8_data", od8, x.d);
                    chk("u8_err", oe8, x.e);
                end
            end
            if (v8 && r8) begin
                x.e = (int'(s8) >= 8);
                x.d = x.e ? 8'h00 : w8[s8];
                q8.push_back(x);
            end
            if (ov5 && or5) begin
                chk("u5_pending", 32'(q5.size() != 0), 1);
                if (q5.size() != 0) begin
                    x = q5.pop_front();
                    chk("u5_data", od5, x.d);
                    chk("u5_err", oe5, x.e);
                end
            end
            if (v5 && r5) begin
                x.e = (int'(s5) >= 5);
                x.d = x.e ? 8'h00 : w5[s5];
                q5.push_back(x);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [2:0] sl5 [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
    logic [7:0] e5d [5] = '{8'hA4, 8'h00, 8'h00, 8'h00, 8'hA2};
    logic       e5e [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int         j_cnt;
    logic [7:0] held;
    logic       a8, a5;

    initial begin
        rst_n = 1'b0;
        v8 = 0; s8 = 0; or8 = 1;
        v5 = 0; s5 = 0; or5 = 1;
        v1 = 0; s1 = 0; or1 = 1; d1 = 8'h00;
        v2 = 0; s2 = 0; or2 = 1;
        for (int k = 0; k < 8; k++) w8[k] = 8'h00;
        for (int k = 0; k < 5; k++) w5[k] = 8'h00;
        w2[0] = 8'h00; w2[1] = 8'h00;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_out_valid", ov8, 0);
        chk("rst_out_data", od8, 8'h00);
        chk("rst_out_err", oe8, 0);
        chk("rst_out_valid_n5", ov5, 0);
        chk("rst_out_valid_n1", ov1, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", r8, 1);
        chk("rst_in_ready_n1", r1, 1);
        chk("rst_in_ready_n2", r2, 1);

        // N=8 back-to-back stream: first output 3 edges after first accept.
        for (int k = 0; k < 8; k++) w8[k] = 8'(8'h10 + k);
        for (int i = 1; i <= 11; i++) begin
            if (i <= 8) begin
                v8 = 1; s8 = 3'(i - 1);
            end else begin
                v8 = 0;
            end
            tick();
            chk("stream_valid", ov8, 32'(i >= 3 && i <= 10));
            if (i >= 3 && i <= 10) chk("stream_data", od8, 32'(8'h10 + i - 3));
        end

        // N=5 with out-of-range selectors.
        for (int k = 0; k < 5; k++) w5[k] = 8'(8'hA0 + k);
        for (int i = 1; i <= 8; i++) begin
            if (i <= 5) begin
                v5 = 1; s5 = sl5[i-1];
            end else begin
                v5 = 0;
            end
            tick();
            chk("n5_valid", ov5, 32'(i >= 3 && i <= 7));
            if (i >= 3 && i <= 7) begin
                chk("n5_data", od5, e5d[i-3]);
                chk("n5_err", oe5, e5e[i-3]);
            end
        end

        // N=8 backpressure: out_ready low for 4 cycles mid-stream.
        for (int k = 0; k < 8; k++) w8[k] = 8'(8'h40 + k);
        j_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            or8 = !(c >= 6 && c < 10);
            if (j_cnt < 12) begin
                v8 = 1; s8 = 3'(j_cnt % 8);
            end else begin
                v8 = 0;
            end
            @(negedge clk);
            if (c >= 6 && c < 10) begin
                chk("bp_in_ready", r8, 0);
                if (c == 6) held = od8;
                else chk("bp_hold", od8, held);
            end
            if (v8 && r8) j_cnt++;
            tick();
        end
        v8 = 0; or8 = 1;
        chk("bp_accepted", j_cnt, 12);
        for (int c = 0; c < 20 && q8.size() != 0; c++) tick();
        chk("bp_drain", q8.size(), 0);

        // N=1 and N=2 with a single stage: latency 1.
        d1 = 8'h5A; s1 = 0; v1 = 1;
        tick();
        chk("n1_valid", ov1, 1);
        chk("n1_data", od1, 8'h5A);
        chk("n1_err", oe1, 0);
        s1 = 1;
        tick();
        chk("n1_oor_data", od1, 8'h00);
        chk("n1_oor_err", oe1, 1);
        v1 = 0;
        tick();
        chk("n1_idle", ov1, 0);

        w2[0] = 8'h33; w2[1] = 8'hCC; s2 = 1; v2 = 1;
        tick();
        chk("n2_valid", ov2, 1);
        chk("n2_data1", od2, 8'hCC);
        s2 = 0;
        tick();
        chk("n2_data0", od2, 8'h33);
        v2 = 0;
        tick();
        chk("n2_idle", ov2, 0);

        // Mid-stream reset with three words in flight.
        for (int k = 0; k < 8; k++) w8[k] = 8'(8'h60 + k);
        or8 = 1;
        for (int i = 0; i < 3; i++) begin
            v8 = 1; s8 = 3'(i + 1);
            tick();
        end
        rst_n = 1'b0; v8 = 0; or8 = 0;
        tick();
        rst_n = 1'b1; or8 = 1;
        chk("mrst_valid", ov8, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mrst_quiet", ov8, 0);
        end
        v8 = 1; s8 = 3'd5;
        tick();
        v8 = 0;
        chk("mrst_lat0", ov8, 0);
        tick();
        chk("mrst_lat1", ov8, 0);
        tick();
        chk("mrst_lat2", ov8, 1);
        chk("mrst_data", od8, 8'h65);

        // Random traffic on N=8 and N=5; sources hold while stalled.
        a8 = 1; a5 = 1;
        for (int c = 0; c < 400; c++) begin
            if (!(v8 && !a8)) begin
                for (int k = 0; k < 8; k++) w8[k] = 8'($urandom);
                s8 = 3'($urandom_range(0, 7));
                v8 = ($urandom_range(0, 3) != 0);
            end
            if (!(v5 && !a5)) begin
                for (int k = 0; k < 5; k++) w5[k] = 8'($urandom);
                s5 = 3'($urandom_range(0, 7));
                v5 = ($urandom_range(0, 3) != 0);
            end
            or8 = ($urandom_range(0, 3) != 0);
            or5 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            a8 = v8 && r8;
            a5 = v5 && r5;
            tick();
        end
        v8 = 0; v5 = 0; or8 = 1; or5 = 1;
        for (int c = 0; c < 20 && (q8.size() != 0 || q5.size() != 0); c++) tick();
        chk("rand_drain8", q8.size(), 0);
        chk("rand_drain5", q5.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N:1 word multiplexer built as a tree of 2:1 levels. It is the registered, multi-bit successor to the combinational generic mux. It handles any input count, including non-powers of two, by passing the odd leftover input through to the next level. Each selected word travels with its own selector through the tree under a valid/ready handshake. It also flags out-of-range selector values. It sits between a bank of parallel sources and a single consumer on the datapath clock.

## Interface
- MUX_SIZE, 8: number of input words N, ≥1.
- DATA_W, 8: width of each input word, ≥1.
- STAGE_EVERY, 1: a register is placed after every STAGE_EVERY tree levels, ≥1.
- SEL_W, derived: max(1, $clog2(MUX_SIZE)). Not to be overridden.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: in_data and in_sel are valid.
- in_ready, output, 1: block accepts an input this cycle.
- in_sel, input, SEL_W: index of the word to select.
- in_data, input, MUX_SIZE*DATA_W: word k occupies bits [k*DATA_W +: DATA_W].
- out_valid, output, 1: out_data and out_err are valid.
- out_ready, input, 1: consumer accepts the output.
- out_data, output, DATA_W: selected word.
- out_err, output, 1: in_sel was ≥ MUX_SIZE for this word.

## Operation
- Tree levels: L = $clog2(MUX_SIZE). There are 0 levels when MUX_SIZE=1.
- Width of level i: n_0 = N and n_{i+1} = ceil(n_i/2).
- At level i, pair (2j, 2j+1) is muxed by sel bit i. Bit i = 0 selects the even element.
- If n_i is odd, the last element passes to index (n_i-1)/2 of level i+1 unchanged, ignoring sel bit i.
- Range check: in_sel ≥ MUX_SIZE is evaluated at input. It forces out_data = 0 and out_err = 1 for that word; the tree result is discarded.
- The check is required because the pass-through path aliases out-of-range indices onto the last input.
- Each stage carries {valid, remaining sel bits, err, partial words} alongside the data.
- Pipeline stages: a register follows level j when (j+1) % STAGE_EVERY == 0 or j == L-1.
- Stage count S = max(1, ceil(L/STAGE_EVERY)). MUX_SIZE=1 gives one register stage holding in_data.
- Flow control is a global stall: advance = ~out_valid | out_ready, and in_ready = advance.
- While advance = 0, every stage holds.
- An input is accepted only when in_valid & in_ready.
- Bubbles (invalid stages) advance like data and are not collapsed.

## Timing
- Reset, synchronous on the rst_n=0 sample: out_valid=0, out_data=0, out_err=0, all stage valids 0.
- in_ready=1 on the first cycle after reset, because out_valid=0.
- Reset mid-stream discards all in-flight words; no partial output appears.
- Latency: a word accepted at edge t appears with out_valid=1 after edge t+S-1 when never stalled. Examples: S=3 for N=8 with STAGE_EVERY=1; S=1 for STAGE_EVERY≥L.
- Throughput: one word per cycle while out_ready=1.
- out_valid=1 with out_ready=0 holds out_data, out_err and all stages stable until the handshake completes.
- in_valid=1 while in_ready=0 is not accepted. The source holds its values; the block does not latch them.
- Simultaneous output handshake and input acceptance in the same cycle is legal and does not lose a word.
- out_data and out_err change only on an advance edge.

## Structure
- Shared package mux_tree_pkg holds:
  - function level_width(n, i), returning n_i;
  - function stage_count(n, every), returning S;
  - function is_reg_level(j, l, every).
- One sub-module: mux_tree_level. It is one combinational tree level, parametrised by input count n_i and DATA_W, and built from mux2-style pair selects plus the odd pass-through.
- The top generates the L levels and the optional stage registers, and holds the handshake logic.

## Test plan
- Reset with N=8, DATA_W=8, STAGE_EVERY=1: hold rst_n=0 for 2 cycles -> out_valid=0, out_data=0x00, out_err=0, in_ready=1 after release.
- N=8, inputs word k = 0x10+k, stream sel 0..7 back-to-back with out_ready=1 -> outputs 0x10..0x17 in order, first one 3 cycles after the first accept, no gaps.
- N=5, words 0xA0..0xA4 -> sel=4 gives 0xA4 with err=0; sel=5, 6, 7 each give 0x00 with err=1; sel=2 gives 0xA2.
- Backpressure, N=8: drop out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, out_data is stable, and the sequence is unbroken with no duplicates.
- N=1 and N=2 with STAGE_EVERY=4 -> latency 1; N=1 sel=0 returns word 0; N=2 sel=1 returns word 1.
- Mid-stream reset with 3 words in flight (N=8) -> none of them appears afterwards; the next accepted word emerges with normal latency.
